mean_window_sv: RTL and testbench
=================================

Name: mean_window_sv

Overview:
- Upstream feeder for the N-sample mean stage.
- Collects a serial stream of B-bit samples into an N-deep window.
- Presents the window as an unpacked array with a one-cycle valid strobe, so the downstream mean stage can consume one complete window per strobe.
- Supports sliding or decimated windows via STRIDE, plus a synchronous flush for stream restarts.

Parameters:
- N, 5, window depth (samples per window); N >= 1.
- B, 10, sample width in bits.
- STRIDE, 1, accepted samples between consecutive emits once the window is full; 1 <= STRIDE <= N (1 = sliding, N = non-overlapping blocks).
- localparam FW = $clog2(N+1), width of the fill counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- i_dval  input  1  sample valid; no backpressure, every valid sample is accepted.
- i_data  input  B  sample value.
- i_flush  input  1  synchronous window clear.
- o_dval  output  1  window-valid strobe, one cycle wide.
- o_data  output  [B-1:0] x [N] (unpacked)  window contents; o_data[0] is oldest, o_data[N-1] is newest.
- o_fill  output  FW  number of valid samples currently held (0..N).

Behaviour:
- Clocking and reset:
  - Single clock.
  - rst is asynchronous, active-high.
  - While rst is high: window registers = 0, o_fill = 0, phase = 0, state = FILL, o_dval = 0.
- Window and ports:
  - o_data is driven directly from the window registers.
  - o_data contents are meaningful only when o_dval = 1; between strobes they change with every accepted sample.
- Accept:
  - On a clock edge with i_dval = 1, shift left: w[k] <= w[k+1], w[N-1] <= i_data.
  - fill <= min(fill+1, N).
- State machine FILL/FULL, evaluated on accepted samples only:
  - FILL: if the new fill == N, then o_dval <= 1, phase <= 0, go to FULL. Otherwise o_dval <= 0.
  - FULL: phase_next = phase + 1. If phase_next == STRIDE, then o_dval <= 1 and phase <= 0; otherwise o_dval <= 0 and phase <= phase_next.
  - Any cycle without an accepted sample: o_dval <= 0. Window, fill and phase hold.
- Latency:
  - o_dval rises on the same edge that writes the completing sample, i.e. one cycle after that sample is presented.
  - o_data in the o_dval cycle includes that sample.
- Flush:
  - i_flush = 1 clears window, fill and phase, sets state = FILL and o_dval <= 0.
  - Flush with i_dval = 1 in the same cycle: the flush applies first, then the sample is accepted. Result: fill = 1, w[N-1] = i_data, w[others] = 0, emit only if N == 1.
- Gaps: i_dval may drop for any number of cycles; the window state is preserved across gaps.
- Width: no arithmetic on data; samples pass through bit-exact. The phase counter is $clog2(STRIDE+1) bits.
- N == 1: every accepted sample emits, STRIDE is forced to 1.
- Reset mid-window: o_dval drops immediately (asynchronously); a full N-sample refill is required before the next emit.

Decomposition:
- Package mean_pkg holds:
  - default N and B constants;
  - typedef sample_t (logic [B-1:0]);
  - the FILL/FULL state enum.
- No sub-module in this block; it is a single module.
- mean_window_sv and mean_sv are wired together in the mean datapath top: o_dval -> i_dval, o_data -> i_data.

Test Plan (defaults N=5, B=10 unless stated):
- STRIDE=1, samples 1,2,3,4,5 on consecutive cycles -> o_dval is high exactly once, one cycle after sample 5, with o_data={1,2,3,4,5} and o_fill=5. Sample 6 next -> o_dval again, o_data={2,3,4,5,6}.
- STRIDE=5, samples 1..12 back-to-back -> exactly two strobes, o_data={1..5} and {6..10}. Samples 11 and 12 give no strobe, and the phase counter reads 2.
- STRIDE=1, samples 10,20,30 with 3-cycle gaps between each, then 40,50 -> no strobe until after 50, then o_data={10,20,30,40,50}. o_dval stays low during the gaps.
- Flush: 3 samples, then i_flush with i_dval carrying 7, then 8,9,10,11 -> o_fill goes 3 -> 1 and there is no strobe until 11, then o_data={7,8,9,10,11}.
- Async reset asserted between edges while full and streaming -> o_dval=0 and o_fill=0 before the next edge, window reads all zeros. After release, the next 4 samples produce no strobe; the 5th produces one.
- Boundary values: samples 1023,0,1023,0,1023 -> o_data bit-exact {1023,0,1023,0,1023}. Chained into mean_sv, the output is 613 one cycle later.

Source files
------------

// File: rtl/mean_pkg.sv
// mean_pkg: shared constants, sample type and window state enum for the mean datapath.
package mean_pkg;
    localparam int N_DEF = 5;
    localparam int B_DEF = 10;
    typedef logic [B_DEF-1:0] sample_t;
    typedef enum logic {ST_FILL, ST_FULL} state_t;
endpackage

// File: rtl/mean_window_sv.sv
// mean_window_sv: collects a serial sample stream into an N-deep window and strobes
// o_dval each time a complete (sliding or decimated) window is ready.
module mean_window_sv
    import mean_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int B      = B_DEF,
    parameter int STRIDE = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_dval,
    input  logic [B-1:0]               i_data,
    input  logic                       i_flush,
    output logic                       o_dval,
    output logic [B-1:0]               o_data [N],
    output logic [$clog2(N+1)-1:0]     o_fill
);
    localparam int FW = $clog2(N+1);
    localparam int SE = (N == 1) ? 1 : STRIDE;
    localparam int PW = $clog2(SE+1);

    logic [B-1:0]  win_q [N];
    logic [B-1:0]  win_d [N];
    logic [FW-1:0] fill_q, fill_d;
    logic [PW-1:0] phase_q, phase_d;
    state_t        state_q, state_d;
    logic          dval_q, dval_d;

    // Flush is applied first so a same-cycle sample lands in a cleared window.
    always_comb begin
        win_d   = win_q;
        fill_d  = fill_q;
        phase_d = phase_q;
        state_d = state_q;
        dval_d  = 1'b0;
        if (i_flush) begin
            for (int k = 0; k < N; k++) win_d[k] = '0;
            fill_d  = '0;
            phase_d = '0;
            state_d = ST_FILL;
        end
        if (i_dval) begin
            for (int k = 0; k < N-1; k++) win_d[k] = win_d[k+1];
            win_d[N-1] = i_data;
            fill_d = (fill_d == FW'(N)) ? fill_d : fill_d + 1'b1;
            if (state_d == ST_FILL) begin
                if (fill_d == FW'(N)) begin
                    dval_d  = 1'b1;
                    phase_d = '0;
                    state_d = ST_FULL;
                end
            end else begin
                dval_d  = (phase_d == PW'(SE-1));
                phase_d = (phase_d == PW'(SE-1)) ? '0 : phase_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q   <= '{default: '0};
            fill_q  <= '0;
            phase_q <= '0;
            state_q <= ST_FILL;
            dval_q  <= 1'b0;
        end else begin
            win_q   <= win_d;
            fill_q  <= fill_d;
            phase_q <= phase_d;
            state_q <= state_d;
            dval_q  <= dval_d;
        end
    end

    assign o_data = win_q;
    assign o_fill = fill_q;
    assign o_dval = dval_q;
endmodule

// File: tb/tb_mean_window_sv.sv
// tb_mean_window_sv: drives STRIDE=1, STRIDE=5 and N=1 instances with one stream and
// checks them against a queue-based model of the window behaviour.
module tb_mean_window_sv;
    import mean_pkg::*;

    logic clk = 1'b0;
    logic rst, i_dval, i_flush;
    sample_t i_data;
    logic v1, v5, vn, fn;
    logic [2:0] f1, f5;
    logic [9:0] d1 [5];
    logic [9:0] d5 [5];
    logic [9:0] dn [1];

    int checks = 0;
    int errors = 0;

    sample_t hist[$];
    int cnt = 0;
    bit acc = 0;

    always #5 clk = ~clk;

    mean_window_sv #(.N(5), .B(10), .STRIDE(1)) dut1 (
        .clk(clk), .rst(rst), .i_dval(i_dval), .i_data(i_data), .i_flush(i_flush),
        .o_dval(v1), .o_data(d1), .o_fill(f1));
    mean_window_sv #(.N(5), .B(10), .STRIDE(5)) dut5 (
        .clk(clk), .rst(rst), .i_dval(i_dval), .i_data(i_data), .i_flush(i_flush),
        .o_dval(v5), .o_data(d5), .o_fill(f5));
    mean_window_sv #(.N(1), .B(10), .STRIDE(3)) dutn (
        .clk(clk), .rst(rst), .i_dval(i_dval), .i_data(i_data), .i_flush(i_flush),
        .o_dval(vn), .o_data(dn), .o_fill(fn));

    typedef struct {
        logic    dv;
        logic    fl;
        sample_t d;
        logic    e_dval;
        int      e_fill;
        int      e_new;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int exp_win(input int k);
        int pad = 5 - hist.size();
        return (k >= pad) ? int'(hist[k-pad]) : 0;
    endfunction

    function automatic bit exp_dval(input int s);
        return acc && cnt >= 5 && ((cnt - 5) % s == 0);
    endfunction

    task automatic model_reset();
        hist.delete();
        cnt = 0;
        acc = 0;
    endtask

    task automatic model_update(input logic dv, input logic fl, input sample_t d);
        if (fl) begin
            hist.delete();
            cnt = 0;
        end
        if (dv) begin
            hist.push_back(d);
            if (hist.size() > 5) void'(hist.pop_front());
            cnt++;
        end
        acc = dv;
    endtask

    task automatic check_all();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("s1_data%0d", k), int'(d1[k]), exp_win(k));
            chk($sformatf("s5_data%0d", k), int'(d5[k]), exp_win(k));
        end
        chk("s1_fill", int'(f1), (cnt < 5) ? cnt : 5);
        chk("s5_fill", int'(f5), (cnt < 5) ? cnt : 5);
        chk("s1_dval", int'(v1), int'(exp_dval(1)));
        chk("s5_dval", int'(v5), int'(exp_dval(5)));
        chk("n1_dval", int'(vn), int'(acc));
        chk("n1_fill", int'(fn), (cnt > 0) ? 1 : 0);
        chk("n1_data", int'(dn[0]), hist.size() ? int'(hist[$]) : 0);
    endtask

    task automatic step(input logic dv, input logic fl, input sample_t d);
        i_dval  = dv;
        i_flush = fl;
        i_data  = d;
        @(posedge clk);
        model_update(dv, fl, d);
        #1;
        check_all();
    endtask

    task automatic chk_win(input string name, input int e0, input int e1, input int e2,
                           input int e3, input int e4);
        int e[5];
        e = '{e0, e1, e2, e3, e4};
        for (int k = 0; k < 5; k++) chk($sformatf("%s_%0d", name, k), int'(d1[k]), e[k]);
    endtask

    vec_t tbl[$];
    int strobes;
    int sum;

    initial begin
        rst = 1'b1; i_dval = 1'b0; i_flush = 1'b0; i_data = '0;
        #2;
        check_all();
        #10;
        rst = 1'b0;

        tbl = '{
            '{1'b1, 1'b0, 10'd1,  1'b0, 1, 1},
            '{1'b1, 1'b0, 10'd2,  1'b0, 2, 2},
            '{1'b1, 1'b0, 10'd3,  1'b0, 3, 3},
            '{1'b1, 1'b0, 10'd4,  1'b0, 4, 4},
            '{1'b1, 1'b0, 10'd5,  1'b1, 5, 5},
            '{1'b1, 1'b0, 10'd6,  1'b1, 5, 6},
            '{1'b0, 1'b1, 10'd0,  1'b0, 0, 0},
            '{1'b1, 1'b0, 10'd1,  1'b0, 1, 1},
            '{1'b1, 1'b0, 10'd2,  1'b0, 2, 2},
            '{1'b1, 1'b0, 10'd3,  1'b0, 3, 3},
            '{1'b1, 1'b1, 10'd7,  1'b0, 1, 7},
            '{1'b1, 1'b0, 10'd8,  1'b0, 2, 8},
            '{1'b1, 1'b0, 10'd9,  1'b0, 3, 9},
            '{1'b1, 1'b0, 10'd10, 1'b0, 4, 10},
            '{1'b1, 1'b0, 10'd11, 1'b1, 5, 11}
        };
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].dv, tbl[i].fl, tbl[i].d);
            chk($sformatf("tbl%0d_dval", i), int'(v1), int'(tbl[i].e_dval));
            chk($sformatf("tbl%0d_fill", i), int'(f1), tbl[i].e_fill);
            chk($sformatf("tbl%0d_new", i), int'(d1[4]), tbl[i].e_new);
        end
        chk_win("flush_win", 7, 8, 9, 10, 11);

        step(1'b0, 1'b1, '0);
        strobes = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b0, sample_t'(i));
            strobes += int'(v5);
            if (i == 5 || i == 10) chk($sformatf("s5_strobe_new%0d", i), int'(d5[4]), i);
        end
        chk("s5_strobes", strobes, 2);
        chk("s5_phase", int'(dut5.phase_q), 2);

        step(1'b0, 1'b1, '0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, sample_t'(10*i));
            if (i < 3) repeat (3) step(1'b0, 1'b0, sample_t'($urandom));
        end
        chk("gap_dval", int'(v1), 1);
        chk_win("gap_win", 10, 20, 30, 40, 50);

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, sample_t'($urandom));
        rst = 1'b1;
        #2;
        model_reset();
        check_all();
        #1;
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, sample_t'(100 + i));
        chk("rst_refill_dval", int'(v1), 1);

        step(1'b0, 1'b1, '0);
        step(1'b1, 1'b0, 10'd1023);
        step(1'b1, 1'b0, 10'd0);
        step(1'b1, 1'b0, 10'd1023);
        step(1'b1, 1'b0, 10'd0);
        step(1'b1, 1'b0, 10'd1023);
        chk_win("bound_win", 1023, 0, 1023, 0, 1023);
        sum = 0;
        for (int k = 0; k < 5; k++) sum += int'(d1[k]);
        chk("bound_mean", sum / 5, 613);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, sample_t'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
